dmem_arbiter: RTL and testbench

Two-port arbiter and load/store formatter in front of the single-ported data memory, which has 1024 words, byte-lane write enables and a registered read. It shares the memory between the CPU load/store port (port 0) and the program-loader/debug port (port 1) using round-robin arbitration. For each granted access it generates the byte-lane write enables and lane-replicated write data, and it aligns and sign- or zero-extends read data returned one cycle later. Misaligned, out-of-range and illegal-size accesses are rejected with an error response and never reach the memory.

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester bus for one data-memory port: request fields out, grant and response back.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;     // sign-extend loads when set
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and load/store formatter for a single-ported data memory
// with byte-lane write enables and a one-cycle registered read.
module dmem_arbiter #(
    parameter int unsigned AW_LIMIT = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        p0,
    dmem_arbiter_if.slave        p1,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_we,
    input  logic [31:0]          mem_rdata
);

    logic        prio_q;  // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic        gnt0, gnt1, any_gnt;
    logic        g_we, g_sext;
    logic [1:0]  g_size;
    logic [31:0] g_addr, g_wdata;
    logic        err_size, err_align, err_range, g_err;

    logic        rsp_valid_q, rsp_owner_q, rsp_we_q, rsp_sext_q, rsp_err_q;
    logic [1:0]  rsp_size_q, rsp_off_q;
    logic [31:0] byte_lane, half_lane, fmt_data, rsp_data;

    // Grant selection and mux of the winning request's fields
    always_comb begin
        gnt0    = p0.req && (!p1.req || !prio_q);
        gnt1    = p1.req && (!p0.req || prio_q);
        any_gnt = gnt0 | gnt1;
        p0.gnt  = gnt0;
        p1.gnt  = gnt1;
        if (gnt1) begin
            g_we    = p1.we;
            g_sext  = p1.sext;
            g_size  = p1.size;
            g_addr  = p1.addr;
            g_wdata = p1.wdata;
        end else begin
            g_we    = p0.we;
            g_sext  = p0.sext;
            g_size  = p0.size;
            g_addr  = p0.addr;
            g_wdata = p0.wdata;
        end
    end

    // Legality checks on the granted request
    always_comb begin
        err_size  = (g_size == 2'b11);
        err_align = ((g_size == 2'b01) && g_addr[0]) ||
                    ((g_size == 2'b10) && (g_addr[1:0] != 2'b00));
        err_range = ((g_addr >> AW_LIMIT) != 32'd0);
        g_err     = err_size | err_align | err_range;
    end

    // Memory-side drive; rejected accesses never reach the memory
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 4'b0000;
        if (any_gnt && !g_err) begin
            mem_addr = {g_addr[31:2], 2'b00};
            if (g_we) begin
                unique case (g_size)
                    2'b00: begin
                        mem_wdata = {4{g_wdata[7:0]}};
                        mem_we    = 4'b0001 << g_addr[1:0];
                    end
                    2'b01: begin
                        mem_wdata = {2{g_wdata[15:0]}};
                        mem_we    = g_addr[1] ? 4'b1100 : 4'b0011;
                    end
                    default: begin
                        mem_wdata = g_wdata;
                        mem_we    = 4'b1111;
                    end
                endcase
            end
        end
    end

    // Response stage and priority pointer; priority passes to the port not just granted
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_sext_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_size_q  <= 2'b00;
            rsp_off_q   <= 2'b00;
        end else begin
            rsp_valid_q <= any_gnt;
            if (any_gnt) begin
                prio_q      <= gnt0;
                rsp_owner_q <= gnt1;
                rsp_we_q    <= g_we;
                rsp_sext_q  <= g_sext;
                rsp_err_q   <= g_err;
                rsp_size_q  <= g_size;
                rsp_off_q   <= g_addr[1:0];
            end
        end
    end

    // Load alignment and extension from the registered memory output
    always_comb begin
        byte_lane = mem_rdata >> {rsp_off_q, 3'b000};
        half_lane = mem_rdata >> {rsp_off_q[1], 4'b0000};
        unique case (rsp_size_q)
            2'b00:   fmt_data = {{24{rsp_sext_q & byte_lane[7]}}, byte_lane[7:0]};
            2'b01:   fmt_data = {{16{rsp_sext_q & half_lane[15]}}, half_lane[15:0]};
            default: fmt_data = mem_rdata;
        endcase
        rsp_data = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? fmt_data : 32'd0;
    end

    // Route the response to the port that owns it
    always_comb begin
        p0.rvalid = rsp_valid_q && !rsp_owner_q;
        p1.rvalid = rsp_valid_q && rsp_owner_q;
        p0.err    = p0.rvalid && rsp_err_q;
        p1.err    = p1.rvalid && rsp_err_q;
        p0.rdata  = rsp_owner_q ? 32'd0 : rsp_data;
        p1.rdata  = rsp_owner_q ? rsp_data : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases plus randomized traffic against a byte-level model.
module tb_dmem_arbiter;
    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic rst;
    dmem_arbiter_if p0 ();
    dmem_arbiter_if p1 ();
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    dmem_arbiter #(.AW_LIMIT(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0),
        .p1        (p1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: 1024 words, byte-lane writes, registered read
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) ram[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        mem_rdata <= ram[mem_addr[11:2]];
    end

    // Staged stimulus (s_*) is applied to the pins (d_*) at the falling edge
    logic        s_rst;
    logic        s_req [2], s_we [2], s_sext [2];
    logic [1:0]  s_size [2];
    logic [31:0] s_addr [2], s_wdata [2];
    logic        d_req [2], d_we [2], d_sext [2];
    logic [1:0]  d_size [2];
    logic [31:0] d_addr [2], d_wdata [2];

    assign p0.req = d_req[0];   assign p1.req = d_req[1];
    assign p0.we = d_we[0];     assign p1.we = d_we[1];
    assign p0.sext = d_sext[0]; assign p1.sext = d_sext[1];
    assign p0.size = d_size[0]; assign p1.size = d_size[1];
    assign p0.addr = d_addr[0]; assign p1.addr = d_addr[1];
    assign p0.wdata = d_wdata[0]; assign p1.wdata = d_wdata[1];

    logic [1:0]  o_gnt;
    logic        o_rv [2], o_err [2];
    logic [31:0] o_rd [2];
    assign o_gnt = {p1.gnt, p0.gnt};
    assign o_rv[0] = p0.rvalid;  assign o_rv[1] = p1.rvalid;
    assign o_err[0] = p0.err;    assign o_err[1] = p1.err;
    assign o_rd[0] = p0.rdata;   assign o_rd[1] = p1.rdata;

    // Reference model state
    logic [7:0]  ref_mem [0:4095];
    int          prio;
    logic        exp_v [2], exp_e [2];
    logic [31:0] exp_d [2];
    int          last_gnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_p(input int p, input logic req, input logic we, input logic [1:0] size,
                         input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
        s_req[p] = req; s_we[p] = we; s_size[p] = size;
        s_sext[p] = sext; s_addr[p] = addr; s_wdata[p] = wdata;
    endtask

    // One clock cycle: apply staged inputs, check against the model, advance the model
    task automatic cycle();
        int          g, nb, lane;
        logic        err;
        logic [31:0] val, wd;
        logic [3:0]  we_m;
        logic [11:0] a;
        @(negedge clk);
        rst = s_rst;
        d_req = s_req; d_we = s_we; d_sext = s_sext;
        d_size = s_size; d_addr = s_addr; d_wdata = s_wdata;
        #1;
        for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("p%0d_rvalid", p), {31'd0, o_rv[p]}, {31'd0, exp_v[p]});
            if (exp_v[p]) begin
                check_eq($sformatf("p%0d_err", p), {31'd0, o_err[p]}, {31'd0, exp_e[p]});
                check_eq($sformatf("p%0d_rdata", p), o_rd[p], exp_d[p]);
            end
        end
        g = -1;
        if (s_req[0] && s_req[1]) g = prio;
        else if (s_req[0])        g = 0;
        else if (s_req[1])        g = 1;
        check_eq("gnt", {30'd0, o_gnt}, (g < 0) ? 32'd0 : (32'd1 << g));
        exp_v[0] = 1'b0; exp_v[1] = 1'b0;
        we_m = 4'b0000;
        if (g >= 0) begin
            nb  = 1 << s_size[g];
            a   = s_addr[g][11:0];
            val = 32'd0;
            if (s_size[g] == 2'd3) err = 1'b1;
            else err = ((s_addr[g] % nb) != 0) || ((s_addr[g] >> AW) != 0);
            if (!err) begin
                check_eq("mem_addr", mem_addr, s_addr[g] & ~32'h3);
                if (s_we[g]) begin
                    for (int i = 0; i < nb; i++) begin
                        lane = int'(a[1:0]) + i;
                        we_m[lane] = 1'b1;
                        ref_mem[a + 12'(i)] = s_wdata[g][8*i +: 8];
                    end
                    if (s_size[g] == 2'd0)      wd = {4{s_wdata[g][7:0]}};
                    else if (s_size[g] == 2'd1) wd = {2{s_wdata[g][15:0]}};
                    else                        wd = s_wdata[g];
                    check_eq("mem_wdata", mem_wdata, wd);
                end else begin
                    for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[a + 12'(i)];
                    if (s_sext[g] && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
                end
            end
            exp_v[g] = 1'b1;
            exp_e[g] = err;
            exp_d[g] = (err || s_we[g]) ? 32'd0 : val;
            prio = 1 - g;
        end
        check_eq("mem_we", {28'd0, mem_we}, {28'd0, we_m});
        if (s_rst) begin
            exp_v[0] = 1'b0; exp_v[1] = 1'b0;
            prio = 0;
        end
        last_gnt = g;
    endtask

    task automatic rand_req(input int p);
        logic [1:0]  sz;
        logic [31:0] ad;
        sz = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
        ad = 32'($urandom_range(0, 255));
        if ($urandom % 4 != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
        if ($urandom % 16 == 0) ad = ad | 32'h0000_1000;
        set_p(p, 1'b1, 1'($urandom), sz, 1'($urandom), ad, $urandom);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        prio = 0; last_gnt = -1;
        exp_v[0] = 1'b0; exp_v[1] = 1'b0;
        exp_e[0] = 1'b0; exp_e[1] = 1'b0;
        exp_d[0] = 32'd0; exp_d[1] = 32'd0;
        set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        s_rst = 1'b1;
        rst = 1'b1;
        d_req = s_req; d_we = s_we; d_sext = s_sext;
        d_size = s_size; d_addr = s_addr; d_wdata = s_wdata;
        repeat (2) @(posedge clk);
        cycle();
        s_rst = 1'b0;
        cycle();
        check_eq("reset_rvalid", {30'd0, o_rv[1], o_rv[0]}, 32'd0);

        // Word store then load
        set_p(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        cycle();
        check_eq("sw_we", {28'd0, mem_we}, 32'hF);
        set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        cycle();
        set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        cycle();
        check_eq("lw_data", o_rd[0], 32'hDEAD_BEEF);

        // Byte and half formatting
        set_p(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01);
        cycle();
        set_p(0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h23, 32'd0);
        cycle();
        set_p(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h22, 32'd0);
        cycle();
        check_eq("lb_signed", o_rd[0], 32'hFFFF_FF80);
        set_p(0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
        cycle();
        check_eq("lbu", o_rd[0], 32'h0000_00FF);
        set_p(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB);
        cycle();
        check_eq("lh_signed", o_rd[0], 32'hFFFF_80FF);
        check_eq("sb_we", {28'd0, mem_we}, 32'h2);
        check_eq("sb_wdata", mem_wdata, 32'hABAB_ABAB);

        // Round-robin from reset
        set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        s_rst = 1'b1;
        cycle();
        s_rst = 1'b0;
        set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        set_p(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("rr_gnt", {30'd0, o_gnt}, (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i > 0)
                check_eq("rr_rvalid", {30'd0, o_rv[1], o_rv[0]}, (i % 2 == 1) ? 32'd1 : 32'd2);
        end

        // Lone P1 request is granted at once
        set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        cycle();
        check_eq("lone_p1_gnt", {30'd0, o_gnt}, 32'd2);
        set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        // Rejected stores: must not disturb memory (0x1000 aliases word 0)
        set_p(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h2, 32'h1111_1111);
        cycle();
        check_eq("err_align_w_we", {28'd0, mem_we}, 32'd0);
        set_p(0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h5, 32'h2222_2222);
        cycle();
        check_eq("err_align_h_we", {28'd0, mem_we}, 32'd0);
        set_p(0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 32'h3333_3333);
        cycle();
        check_eq("err_size_we", {28'd0, mem_we}, 32'd0);
        set_p(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h4444_4444);
        cycle();
        check_eq("err_range_we", {28'd0, mem_we}, 32'd0);
        set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
        cycle();
        check_eq("err_range_rsp", {30'd0, o_err[0], o_rv[0]}, 32'd3);
        set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'd0);
        cycle();
        check_eq("err_mem_kept", o_rd[0], 32'd0);

        // Reset while both ports stream loads
        set_p(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        repeat (3) cycle();
        s_rst = 1'b1;
        cycle();
        s_rst = 1'b0;
        cycle();
        check_eq("rst_mid_rvalid", {30'd0, o_rv[1], o_rv[0]}, 32'd0);
        check_eq("rst_mid_gnt", {30'd0, o_gnt}, 32'd1);

        // Store-half then load of the same word on the other port
        set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        set_p(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hAABB_CCDD);
        cycle();
        set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        set_p(1, 1'b1, 1'b1, 2'd1, 1'b0, 32'h40, 32'h0000_1234);
        cycle();
        set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
        cycle();
        set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        cycle();
        check_eq("hazard_lw", o_rd[0], 32'hAABB_1234);

        // Randomized traffic; a request is held until the model says it was granted
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!s_req[p] || last_gnt == p) begin
                    if ($urandom % 4 != 0) rand_req(p);
                    else s_req[p] = 1'b0;
                end
            end
            cycle();
        end
        set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
